// File: rtl/ni_output_unit_mc.sv
// NI output unit, multi-channel: per-source FIFOs, round-robin arbitration under
// credit flow control toward the router local port, and a drain-then-FIN sequence.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | normal operation, sources may push
// DRAIN    | fin_comp seen; pushes blocked, queued flits still leave
// SEND_FIN | FIFOs empty; waiting for a credit to emit the FIN flit
module ni_output_unit_mc #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 6,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CREDIT_MAX = 4,
  parameter int FIN_DEST   = 0,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int FLIT_W    = 1 + CH_W + ADDR_W + DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [5:0]               PE_IDX,
  input  logic [NUM_CH-1:0]        src_valid,
  output logic [NUM_CH-1:0]        src_ready,
  input  logic [NUM_CH*ADDR_W-1:0] src_addr,
  input  logic [NUM_CH*DATA_W-1:0] src_data,
  input  logic                     fin_comp,
  input  logic                     downstream_credit,
  output logic                     out_data_valid,
  output logic [FLIT_W-1:0]        out_data,
  output logic                     router_rdy,
  output logic                     fin_busy,
  output logic                     credit_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CRD_W = $clog2(CREDIT_MAX + 1);
  localparam int ENT_W = ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    SEND_FIN = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [ENT_W-1:0]  mem_q    [NUM_CH][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_q    [NUM_CH];

  logic [NUM_CH-1:0] full, empty, push, pop;
  logic              all_empty;

  logic [CH_W-1:0]   rr_q, rr_d;
  logic [CH_W-1:0]   grant;
  logic              grant_vld;
  logic [ENT_W-1:0]  head_sel;

  logic [CRD_W-1:0]  credit_q, credit_d;
  logic              credit_err_q, credit_err_d;
  logic              out_valid_q, out_valid_d;
  logic [FLIT_W-1:0] out_data_q, out_data_d;

  logic              send_data, send_fin, send_any;
  logic [DATA_W-1:0] fin_payload;

  assign src_ready      = ~full & {NUM_CH{state_q == IDLE}};
  assign all_empty      = &empty;
  assign fin_payload    = DATA_W'(PE_IDX);
  assign router_rdy     = (credit_q != '0);
  assign fin_busy       = (state_q != IDLE);
  assign credit_err     = credit_err_q;
  assign out_data_valid = out_valid_q;
  assign out_data       = out_data_q;

  // SEND_FIN is only reached with every FIFO empty, so data never competes with FIN.
  assign send_data = grant_vld && (credit_q != '0) && (state_q != SEND_FIN);
  assign send_any  = send_data || send_fin;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      full[i]  = (cnt_q[i] == CNT_W'(FIFO_DEPTH));
      empty[i] = (cnt_q[i] == '0);
      push[i]  = src_valid[i] && src_ready[i];
      pop[i]   = send_data && (grant == CH_W'(i));
    end
  end

  // Round-robin: channels above the pointer first, then wrap to those at or below it.
  always_comb begin
    grant_vld = 1'b0;
    grant     = rr_q;
    for (int j = 0; j < NUM_CH; j++) begin
      if (!grant_vld && !empty[j] && (j > int'(rr_q))) begin
        grant_vld = 1'b1;
        grant     = CH_W'(j);
      end
    end
    for (int j = 0; j < NUM_CH; j++) begin
      if (!grant_vld && !empty[j] && (j <= int'(rr_q))) begin
        grant_vld = 1'b1;
        grant     = CH_W'(j);
      end
    end
    head_sel = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (grant == CH_W'(j)) begin
        head_sel = mem_q[j][rd_ptr_q[j]];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    send_fin    = 1'b0;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    rr_d        = rr_q;
    case (state_q)
      IDLE: begin
        if (fin_comp) state_d = DRAIN;
      end
      DRAIN: begin
        if (all_empty && !send_data) state_d = SEND_FIN;
      end
      SEND_FIN: begin
        if (credit_q != '0) begin
          send_fin = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (send_data) begin
      out_valid_d = 1'b1;
      out_data_d  = {1'b0, grant, head_sel};
      rr_d        = grant;
    end else if (send_fin) begin
      out_valid_d = 1'b1;
      out_data_d  = {1'b1, CH_W'(0), ADDR_W'(FIN_DEST), fin_payload};
    end
  end

  // A return that coincides with a send cancels out; a surplus return at full is an error.
  always_comb begin
    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    if (send_any && !downstream_credit) begin
      credit_d = credit_q - CRD_W'(1);
    end else if (!send_any && downstream_credit) begin
      if (credit_q == CRD_W'(CREDIT_MAX)) begin
        credit_err_d = 1'b1;
      end else begin
        credit_d = credit_q + CRD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rr_q         <= CH_W'(NUM_CH - 1);
      credit_q     <= CRD_W'(CREDIT_MAX);
      credit_err_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      credit_q     <= credit_d;
      credit_err_q <= credit_err_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
        if (push[i] && !pop[i]) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end else if (pop[i] && !push[i]) begin
          cnt_q[i] <= cnt_q[i] - CNT_W'(1);
        end
      end
    end
  end

  // Storage needs no reset: the counters alone decide what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= {src_addr[i*ADDR_W +: ADDR_W], src_data[i*DATA_W +: DATA_W]};
      end
    end
  end

endmodule

// File: doc/ni_output_unit_mc.md
Name: ni_output_unit_mc

Overview:
- Multi-channel, parametrised successor to the single-stream NI output path.
- Accepts activation/read-response traffic from NUM_CH independent PE-side sources, each buffered in its own FIFO.
- Arbitrates round-robin under credit-based flow control toward the leaf router's local port.
- On fin_comp, drains all channels, then emits a single FIN flit.

Parameters:
- DATA_W, 16: payload width.
- ADDR_W, 6: router destination address width.
- NUM_CH, 2: number of source channels (1..8).
- FIFO_DEPTH, 4: entries per channel FIFO (power of 2, >=2).
- CREDIT_MAX, 4: downstream buffer depth, i.e. the reset credit count.
- FIN_DEST, 0: destination address carried by the FIN flit.
- Derived: CH_W = max(1, clog2(NUM_CH)); FLIT_W = 1+CH_W+ADDR_W+DATA_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- PE_IDX  in  6  PE index; carried in the FIN payload.
- src_valid  in  NUM_CH  per-channel push request.
- src_ready  out  NUM_CH  per-channel FIFO can accept.
- src_addr  in  NUM_CH*ADDR_W  per-channel destination; channel i at [i*ADDR_W +: ADDR_W].
- src_data  in  NUM_CH*DATA_W  per-channel payload.
- fin_comp  in  1  single-cycle pulse: layer computation finished.
- downstream_credit  in  1  one credit returned by the router.
- out_data_valid  out  1  flit valid, one cycle per flit.
- out_data  out  FLIT_W  flit {is_fin, ch_idx, addr, data}.
- router_rdy  out  1  credit count > 0.
- fin_busy  out  1  FSM not in IDLE.
- credit_err  out  1  sticky: credit returned while already at CREDIT_MAX.

Behaviour:
- Reset (rst=0, asynchronous):
  - All FIFOs empty; credit = CREDIT_MAX; RR pointer = NUM_CH-1, so channel 0 has first priority.
  - FSM = IDLE.
  - out_data_valid=0, out_data=0, credit_err=0, fin_busy=0.
  - src_ready is all-ones once rst deasserts.
- Push:
  - src_ready[i] = !full[i] && (FSM==IDLE).
  - Entry written at the edge where src_valid[i] && src_ready[i].
  - Valid without ready: no write, no error; the source holds its request.
- Arbitration, evaluated each cycle:
  - Eligible when credit > 0 and at least one FIFO is non-empty.
  - Grant = first non-empty channel strictly after the RR pointer, wrapping modulo NUM_CH.
  - On grant, at the edge: pop the head, register out_data = {0, grant, addr, data}, pulse out_data_valid, set pointer = grant, decrement credit.
  - Latency: entry accepted at edge N reaches out_data_valid=1 in the cycle after edge N+1, if credit is available and no other channel wins.
  - Push and pop on the same FIFO in the same cycle are both honoured; a full FIFO does not accept, even if popping.
- Credit counter, width clog2(CREDIT_MAX+1):
  - Send only: -1. downstream_credit only: +1. Both in the same cycle: unchanged.
  - Never sends at 0.
  - Credit returned at CREDIT_MAX with no simultaneous send: saturate and set credit_err (cleared only by reset).
- router_rdy = (credit != 0), combinational from the registered credit count.
- FIN FSM:
  - IDLE: fin_comp -> DRAIN.
  - DRAIN: pushes blocked; arbitration continues. When all FIFOs are empty and no flit is being registered this cycle -> SEND_FIN.
  - SEND_FIN: wait for credit > 0, then register out_data = {1, 0, FIN_DEST, zero-extended PE_IDX}, pulse valid, decrement credit -> IDLE.
  - fin_comp outside IDLE is ignored.
  - fin_comp with all FIFOs already empty: DRAIN lasts exactly one cycle.
  - fin_busy = (FSM != IDLE).
- Reset mid-operation drops all queued flits and any pending FIN, and restores credits.
- No combinational path from inputs to out_data / out_data_valid; both are registered.

Test Plan:
- Reset, then 1 push ch0 (addr=5, data=0x1234), credit=4 -> out_data_valid one cycle after the next edge, out_data={0,0,5,0x1234}, credit=3.
- Both channels push 3 entries simultaneously, no credit returns -> exactly 4 flits in order ch0,ch1,ch0,ch1, then router_rdy=0 and the remaining 2 entries are held. Return 2 credits -> ch0,ch1 emitted.
- Fill ch1 with 4 entries while credit=0 -> src_ready[1]=0 after the 4th push; a 5th src_valid is not written. Return 1 credit -> src_ready[1] rises one cycle after the pop.
- fin_comp with 2 queued ch0 entries, PE_IDX=13 -> src_ready=0 during drain; 2 data flits, then FIN flit {1,0,FIN_DEST,13}; fin_busy falls the cycle after FIN.
- downstream_credit pulsed at credit=4 with no send -> credit stays 4, credit_err=1 and remains set. Simultaneous send and credit at credit=2 -> credit stays 2.
- Assert rst low mid-DRAIN with queued data -> outputs at reset values immediately, no FIN emitted, router_rdy=1 after release.
